host_output_schedule: RTL and testbench

Strict-priority descriptor scheduler that sits in front of host_tx and drives its descriptor port (iv_pkt_descriptor / i_pkt_descriptor_wr / o_pkt_descriptor_ready).
- Upstream classification delivers 13-bit descriptors ({inport[3:0], bufid[8:0]}) tagged with a 2-bit traffic class.
- Descriptors are buffered in three per-class FIFOs: 0 = TS, 1 = RC, 2 = BE.
- One descriptor at a time is issued to host_tx whenever host_tx signals ready.

---
 rtl/host_output_schedule_pkg.sv | 28 ++
 rtl/hos_desc_fifo.sv | 45 ++++
 rtl/host_output_schedule.sv | 105 ++++++++++
 tb/tb_host_output_schedule.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_output_schedule_pkg.sv
// Shared definitions for the strict-priority host descriptor scheduler.
package host_output_schedule_pkg;

    localparam int DESC_W  = 13;
    localparam int NUM_CLS = 3;

    localparam logic [1:0] CLS_TS  = 2'd0;
    localparam logic [1:0] CLS_RC  = 2'd1;
    localparam logic [1:0] CLS_BE  = 2'd2;
    localparam logic [1:0] CLS_INV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [3:0] inport;
        logic [8:0] bufid;
    } desc_t;

    typedef struct packed {
        desc_t      desc;
        logic [1:0] cls;
    } enq_req_t;

endpackage

// File: rtl/hos_desc_fifo.sv
// Register FIFO for one traffic class; head is combinational from the read pointer.
module hos_desc_fifo
    import host_output_schedule_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic  gclk,
    input  logic  grst_n,
    input  logic  push,
    input  desc_t push_data,
    input  logic  pop,
    output desc_t head,
    output logic  full,
    output logic  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2:0] ptr_t;

    desc_t mem [DEPTH];
    ptr_t  wr_ptr, rd_ptr;
    logic  do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge gclk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/host_output_schedule.sv
// Strict-priority (TS > RC > BE) scheduler feeding host_tx one descriptor at a time,
// with a guard window after each issue while host_tx drops its ready.
module host_output_schedule
    import host_output_schedule_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DESC_W-1:0] iv_pkt_descriptor,
    input  logic [1:0]        iv_pkt_class,
    input  logic              i_pkt_descriptor_wr,
    output logic [DESC_W-1:0] ov_pkt_descriptor,
    output logic              o_pkt_descriptor_wr,
    input  logic              i_pkt_descriptor_ready,
    output logic [2:0]        ov_queue_empty,
    output logic              o_discard_pulse,
    output logic [15:0]       ov_discard_cnt,
    output logic [1:0]        ov_sched_state
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [1:0] CLS_CODE [NUM_CLS] = '{CLS_TS, CLS_RC, CLS_BE};

    enq_req_t           req;
    logic [NUM_CLS-1:0] push, pop, full, empty, sel;
    desc_t              head [NUM_CLS];
    desc_t              issue_desc, last_desc_q;
    logic               drop, issuing;
    sched_state_e       state_q, state_d;
    logic [GW-1:0]      guard_q;

    assign req = {iv_pkt_descriptor, iv_pkt_class};

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_cls
        assign push[c] = i_pkt_descriptor_wr && (req.cls == CLS_CODE[c]) && !full[c];

        hos_desc_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
            .gclk      (i_clk),
            .grst_n    (i_rst_n),
            .push      (push[c]),
            .push_data (req.desc),
            .pop       (pop[c]),
            .head      (head[c]),
            .full      (full[c]),
            .empty     (empty[c])
        );
    end

    // Any write that found no accepting queue (invalid class or full) is a drop;
    // full is taken from pre-edge pointers so a same-cycle pop never frees room.
    assign drop = i_pkt_descriptor_wr && (push == '0);

    always_comb begin
        sel        = '0;
        issue_desc = '0;
        for (int c = NUM_CLS - 1; c >= 0; c--) begin
            if (!empty[c]) begin
                sel        = '0;
                sel[c]     = 1'b1;
                issue_desc = head[c];
            end
        end
    end

    assign issuing = (state_q == ST_ISSUE) && !(&empty);
    assign pop     = issuing ? sel : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!(&empty) && i_pkt_descriptor_ready) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_GUARD;
            ST_GUARD: if (guard_q <= GW'(1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_IDLE;
            guard_q         <= '0;
            last_desc_q     <= '0;
            o_discard_pulse <= 1'b0;
            ov_discard_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ISSUE)
                guard_q <= GW'(GUARD_CYCLES);
            else if (state_q == ST_GUARD && guard_q != '0)
                guard_q <= guard_q - GW'(1);
            if (issuing) last_desc_q <= issue_desc;
            o_discard_pulse <= drop;
            if (drop && ov_discard_cnt != 16'hFFFF)
                ov_discard_cnt <= ov_discard_cnt + 16'd1;
        end
    end

    assign ov_pkt_descriptor   = issuing ? issue_desc : last_desc_q;
    assign o_pkt_descriptor_wr = issuing;
    assign ov_queue_empty      = empty;
    assign ov_sched_state      = state_q;

endmodule

// File: tb/tb_host_output_schedule.sv
// Scoreboard bench: per-class reference queues, monitor checks every cycle on the falling edge.
module tb_host_output_schedule;
    import host_output_schedule_pkg::*;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int G     = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [12:0] iv_pkt_descriptor = '0;
    logic [1:0]  iv_pkt_class = '0;
    logic        i_pkt_descriptor_wr = 1'b0;
    logic        i_pkt_descriptor_ready = 1'b0;
    logic [12:0] ov_pkt_descriptor;
    logic        o_pkt_descriptor_wr;
    logic [2:0]  ov_queue_empty;
    logic        o_discard_pulse;
    logic [15:0] ov_discard_cnt;
    logic [1:0]  ov_sched_state;

    host_output_schedule #(.DEPTH_LOG2(DL), .GUARD_CYCLES(G)) dut (
        .i_clk                  (i_clk),
        .i_rst_n                (i_rst_n),
        .iv_pkt_descriptor      (iv_pkt_descriptor),
        .iv_pkt_class           (iv_pkt_class),
        .i_pkt_descriptor_wr    (i_pkt_descriptor_wr),
        .ov_pkt_descriptor      (ov_pkt_descriptor),
        .o_pkt_descriptor_wr    (o_pkt_descriptor_wr),
        .i_pkt_descriptor_ready (i_pkt_descriptor_ready),
        .ov_queue_empty         (ov_queue_empty),
        .o_discard_pulse        (o_discard_pulse),
        .ov_discard_cnt         (ov_discard_cnt),
        .ov_sched_state         (ov_sched_state)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [12:0] q0[$], q1[$], q2[$];
    int          exp_cnt = 0;
    bit          exp_pulse = 0;
    bit          ready_prev = 0;
    int          last_issue = -1;
    logic [12:0] last_val = '0;
    int          issue_cycles[$];
    logic [12:0] issued_vals[$];
    int          icls, cc;
    logic [12:0] e;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(int c);
        case (c)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void qpush(int c, logic [12:0] d);
        case (c)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endfunction

    function automatic logic [12:0] qpop(int c);
        case (c)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    always @(posedge i_clk or negedge i_rst_n)
        if (i_rst_n) cyc <= cyc + 1;

    // Model: checks this cycle's outputs, consumes an issue, then books the write
    // that the coming edge will sample (full judged before this cycle's pop lands).
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            q0.delete(); q1.delete(); q2.delete();
            exp_cnt = 0; exp_pulse = 0; last_issue = -1; last_val = '0; ready_prev = 0;
        end else begin
            check("queue_empty", 32'(ov_queue_empty),
                  32'({q2.size() == 0, q1.size() == 0, q0.size() == 0}));
            check("discard_pulse", 32'(o_discard_pulse), 32'(exp_pulse));
            check("discard_cnt", 32'(ov_discard_cnt), 32'(exp_cnt));
            icls = -1;
            if (o_pkt_descriptor_wr) begin
                check("ready_seen_before_issue", 32'(ready_prev), 1);
                if (last_issue >= 0) check("issue_spacing", 32'(cyc - last_issue >= G + 2), 1);
                for (int c = 2; c >= 0; c--) if (qsize(c) != 0) icls = c;
                if (icls < 0) check("issue_unexpected", 1, 0);
                else begin
                    e = qpop(icls);
                    check("issue_desc", 32'(ov_pkt_descriptor), 32'(e));
                end
                last_val   = ov_pkt_descriptor;
                last_issue = cyc;
                issue_cycles.push_back(cyc);
                issued_vals.push_back(ov_pkt_descriptor);
            end else begin
                check("desc_hold", 32'(ov_pkt_descriptor), 32'(last_val));
            end
            ready_prev = i_pkt_descriptor_ready;
            exp_pulse  = 0;
            if (i_pkt_descriptor_wr) begin
                cc = int'(iv_pkt_class);
                if (cc == 3 || qsize(cc) + ((icls == cc) ? 1 : 0) >= DEPTH) begin
                    exp_pulse = 1;
                    if (exp_cnt < 65535) exp_cnt++;
                end else begin
                    qpush(cc, iv_pkt_descriptor);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(logic [12:0] d, logic [1:0] c);
        iv_pkt_descriptor   = d;
        iv_pkt_class        = c;
        i_pkt_descriptor_wr = 1'b1;
        tick();
        i_pkt_descriptor_wr = 1'b0;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_empty"}, 32'(ov_queue_empty), 32'h7);
        check({tag, "_wr"},    32'(o_pkt_descriptor_wr), 0);
        check({tag, "_desc"},  32'(ov_pkt_descriptor), 0);
        check({tag, "_pulse"}, 32'(o_discard_pulse), 0);
        check({tag, "_cnt"},   32'(ov_discard_cnt), 0);
        check({tag, "_state"}, 32'(ov_sched_state), 0);
    endtask

    task automatic drain(string tag);
        int i;
        i_pkt_descriptor_ready = 1'b1;
        for (i = 0; i < 1000 && (q0.size() + q1.size() + q2.size()) != 0; i++) tick();
        if (i >= 1000) check({tag, "_drain_timeout"}, 0, 1);
        repeat (6) tick();
    endtask

    initial begin
        int k, n0;
        // reset
        repeat (3) tick();
        check_reset_vals("rst0");
        i_rst_n = 1'b1;
        tick();

        // single BE, enqueue-to-issue latency
        i_pkt_descriptor_ready = 1'b1;
        k  = cyc;
        n0 = issue_cycles.size();
        drive(13'h0A05, CLS_BE);
        for (int i = 0; i < 10 && issue_cycles.size() == n0; i++) tick();
        if (issue_cycles.size() == n0) check("first_issue_timeout", 0, 1);
        else begin
            check("enq_to_issue_latency", 32'(issue_cycles[n0] - k), 2);
            check("first_issue_val", 32'(issued_vals[n0]), 32'h0A05);
        end
        drain("single");
        check("single_empty_after", 32'(ov_queue_empty), 32'h7);

        // priority ordering and issue spacing
        i_pkt_descriptor_ready = 1'b0;
        drive(13'h0001, CLS_BE);
        drive(13'h0002, CLS_RC);
        drive(13'h0003, CLS_TS);
        repeat (2) tick();
        n0 = issue_cycles.size();
        drain("prio");
        if (issue_cycles.size() < n0 + 3) check("prio_issue_count", 32'(issue_cycles.size() - n0), 3);
        else begin
            check("prio_first",  32'(issued_vals[n0]),     32'h0003);
            check("prio_second", 32'(issued_vals[n0 + 1]), 32'h0002);
            check("prio_third",  32'(issued_vals[n0 + 2]), 32'h0001);
            check("prio_gap1", 32'(issue_cycles[n0 + 1] - issue_cycles[n0]), G + 2);
            check("prio_gap2", 32'(issue_cycles[n0 + 2] - issue_cycles[n0 + 1]), G + 2);
        end

        // TS overflow: 16 stored, 17th dropped
        i_pkt_descriptor_ready = 1'b0;
        for (int i = 0; i < 17; i++) drive(13'(13'h0100 + i), CLS_TS);
        check("ovf_pulse", 32'(o_discard_pulse), 1);
        check("ovf_cnt", 32'(ov_discard_cnt), 1);
        tick();
        check("ovf_pulse_single", 32'(o_discard_pulse), 0);
        n0 = issue_cycles.size();
        drain("ovf");
        check("ovf_drained", 32'(issue_cycles.size() - n0), 16);

        // invalid class
        n0 = issue_cycles.size();
        drive(13'h0111, CLS_INV);
        check("inv_pulse", 32'(o_discard_pulse), 1);
        repeat (4) tick();
        check("inv_cnt", 32'(ov_discard_cnt), 2);
        check("inv_empty", 32'(ov_queue_empty), 32'h7);
        check("inv_no_issue", 32'(issue_cycles.size() - n0), 0);

        // reset mid-guard with all classes loaded
        i_pkt_descriptor_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(13'(13'h0200 + i), CLS_TS);
            drive(13'(13'h0300 + i), CLS_RC);
            drive(13'(13'h0400 + i), CLS_BE);
        end
        i_pkt_descriptor_ready = 1'b1;
        for (k = 0; k < 10 && !o_pkt_descriptor_wr; k++) tick();
        if (k >= 10) check("guard_issue_timeout", 0, 1);
        tick();
        check("in_guard", 32'(ov_sched_state), 2);
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        repeat (2) tick();
        i_rst_n = 1'b1;
        n0 = issue_cycles.size();
        repeat (10) tick();
        check("post_rst_no_issue", 32'(issue_cycles.size() - n0), 0);
        check("post_rst_empty", 32'(ov_queue_empty), 32'h7);

        // continuous BE stream with ready held high
        i_pkt_descriptor_ready = 1'b1;
        for (int i = 0; i < 40; i++) drive(13'(13'h0800 + i), CLS_BE);
        check("stream_drops_seen", 32'(ov_discard_cnt != 0), 1);
        drain("stream");

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            iv_pkt_descriptor      = 13'($urandom);
            iv_pkt_class           = 2'($urandom_range(0, 3));
            i_pkt_descriptor_wr    = ($urandom_range(0, 9) < 6);
            i_pkt_descriptor_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_pkt_descriptor_wr = 1'b0;
        drain("rand");
        check("rand_final_empty", 32'(ov_queue_empty), 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
